// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and helpers for the Huffman code generator/decoder pair.
package huffman_pkg;

  localparam int CODE_W  = 13;
  localparam int LEN_HI  = 12;
  localparam int LEN_LO  = 9;
  localparam int CODE_HI = 8;
  localparam int MAX_LEN = 9;
  localparam int SYM_NUM = 10;
  localparam int SYM_W   = 4;
  localparam int LEN_W   = LEN_HI - LEN_LO + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  // Mask selecting the low 'len' bits of a right-aligned code.
  function automatic logic [CODE_HI:0] len_mask(input logic [LEN_W-1:0] len);
    logic [CODE_HI:0] m;
    for (int i = 0; i <= CODE_HI; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/huffman_match.sv
// Combinational table lookup: compares the candidate code against all entries and
// priority-encodes the lowest-index hit.
import huffman_pkg::*;

module huffman_match (
  input  logic [SYM_NUM-1:0][CODE_W-1:0] entries,
  input  logic [CODE_HI:0]               nxt_acc,
  input  logic [LEN_W-1:0]               nxt_len,
  output logic                           hit,
  output logic [SYM_W-1:0]               hit_idx
);

  logic [SYM_NUM-1:0] hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < SYM_NUM; gi++) begin : g_entry
      logic [LEN_W-1:0] len_i;
      assign len_i = entries[gi][LEN_HI:LEN_LO];
      assign hit_vec[gi] = (len_i != '0) && (len_i == nxt_len) &&
                           (((entries[gi][CODE_HI:0] ^ nxt_acc) & len_mask(len_i)) == '0);
    end
  endgenerate

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit     = |hit_vec;
    hit_idx = '0;
    for (int i = SYM_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_idx = SYM_W'(i);
      end
    end
  end

endmodule

// File: rtl/huffman_decode.sv
// Streaming Huffman decoder: one bit per cycle in, symbols 0-9 out over valid/ready.
// Optional error counter output enabled by defining HUFF_DEC_ERR_CNT_EN.
import huffman_pkg::*;

module huffman_decode (
  input  logic        Clk_in,
  input  logic        Rst,
  input  logic        Load_table,
  input  logic [12:0] Code0,
  input  logic [12:0] Code1,
  input  logic [12:0] Code2,
  input  logic [12:0] Code3,
  input  logic [12:0] Code4,
  input  logic [12:0] Code5,
  input  logic [12:0] Code6,
  input  logic [12:0] Code7,
  input  logic [12:0] Code8,
  input  logic [12:0] Code9,
  input  logic        Bit_in,
  input  logic        Bit_valid,
  output logic        Bit_ready,
  output logic [3:0]  Sym_out,
  output logic        Sym_valid,
  input  logic        Sym_ready,
  output logic        Err,
`ifdef HUFF_DEC_ERR_CNT_EN
  output logic [7:0]  Err_cnt,
`endif
  output logic        Tbl_ok
);

  state_t state_reg, state_next;
  logic   tbl_ok;

  logic [SYM_NUM-1:0][CODE_W-1:0] table_reg;
  logic [SYM_NUM-1:0][CODE_W-1:0] code_in;

  // Only 8 history bits are kept: a 9th bit always ends the code (hit or error).
  logic [CODE_HI-1:0] hist_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [SYM_W-1:0]   sym_reg;
  logic               sym_valid_reg;
  logic               err_reg;

  logic               accept;
  logic               hit;
  logic               err_event;
  logic [SYM_W-1:0]   hit_idx;
  logic [CODE_HI:0]   nxt_acc;
  logic [LEN_W-1:0]   nxt_len;

  assign code_in = {Code9, Code8, Code7, Code6, Code5, Code4, Code3, Code2, Code1, Code0};

  // State register
  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      state_reg <= S_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_EMPTY: if (Load_table) state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_EMPTY;
    endcase
  end

  // State outputs
  always_comb begin
    tbl_ok = (state_reg == S_RUN);
  end

  assign Bit_ready = tbl_ok & ~Load_table & ~(sym_valid_reg & ~Sym_ready);
  assign accept    = Bit_valid & Bit_ready;
  assign nxt_acc   = {hist_reg, Bit_in};
  assign nxt_len   = len_reg + LEN_W'(1);
  assign err_event = accept & ~hit & (nxt_len == LEN_W'(MAX_LEN));

  huffman_match u_match (
    .entries (table_reg),
    .nxt_acc (nxt_acc),
    .nxt_len (nxt_len),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      table_reg     <= '0;
      hist_reg      <= '0;
      len_reg       <= '0;
      sym_reg       <= '0;
      sym_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (Load_table) begin
        table_reg     <= code_in;
        hist_reg      <= '0;
        len_reg       <= '0;
        sym_reg       <= '0;
        sym_valid_reg <= 1'b0;
      end else begin
        if (sym_valid_reg && Sym_ready) begin
          sym_valid_reg <= 1'b0;
        end
        // A hit on the same edge as a consume overrides the clear above.
        if (accept) begin
          if (hit) begin
            sym_reg       <= hit_idx;
            sym_valid_reg <= 1'b1;
            hist_reg      <= '0;
            len_reg       <= '0;
          end else if (err_event) begin
            err_reg  <= 1'b1;
            hist_reg <= '0;
            len_reg  <= '0;
          end else begin
            hist_reg <= nxt_acc[CODE_HI-1:0];
            len_reg  <= nxt_len;
          end
        end
      end
    end
  end

`ifdef HUFF_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge Clk_in) begin
    if (Rst || Load_table) begin
      err_cnt_reg <= '0;
    end else if (err_event && (err_cnt_reg != 8'hff)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign Err_cnt = err_cnt_reg;
`endif

  assign Sym_out   = sym_reg;
  assign Sym_valid = sym_valid_reg;
  assign Err       = err_reg;
  assign Tbl_ok    = tbl_ok;

endmodule

// File: tb/tb_huffman_decode.sv
// Self-checking bench for huffman_decode: table-driven bit streams with a symbol
// scoreboard, plus hand-written latency, backpressure, reload and reset sequences.
`timescale 1ns/1ps

module tb_huffman_decode;

  logic        Clk_in = 1'b0;
  logic        Rst = 1'b1;
  logic        Load_table = 1'b0;
  logic [12:0] code [10];
  logic        Bit_in = 1'b0;
  logic        Bit_valid = 1'b0;
  logic        Bit_ready;
  logic [3:0]  Sym_out;
  logic        Sym_valid;
  logic        Sym_ready = 1'b1;
  logic        Err;
  logic        Tbl_ok;
`ifdef HUFF_DEC_ERR_CNT_EN
  logic [7:0]  Err_cnt;
`endif

  huffman_decode dut (
    .Clk_in     (Clk_in),
    .Rst        (Rst),
    .Load_table (Load_table),
    .Code0      (code[0]),
    .Code1      (code[1]),
    .Code2      (code[2]),
    .Code3      (code[3]),
    .Code4      (code[4]),
    .Code5      (code[5]),
    .Code6      (code[6]),
    .Code7      (code[7]),
    .Code8      (code[8]),
    .Code9      (code[9]),
    .Bit_in     (Bit_in),
    .Bit_valid  (Bit_valid),
    .Bit_ready  (Bit_ready),
    .Sym_out    (Sym_out),
    .Sym_valid  (Sym_valid),
    .Sym_ready  (Sym_ready),
    .Err        (Err),
`ifdef HUFF_DEC_ERR_CNT_EN
    .Err_cnt    (Err_cnt),
`endif
    .Tbl_ok     (Tbl_ok)
  );

  always #5 Clk_in = ~Clk_in;

  typedef struct {
    int          tab;
    logic [31:0] bits;   // MSB-first, low nbits used
    int          nbits;
    logic [23:0] syms;   // symbol k in nibble k
    int          nsyms;
    int          nerr;
  } vec_t;

  vec_t       vecs [4];
  int         checks = 0;
  int         passes = 0;
  int         err_seen = 0;
  logic [3:0] sb [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void set_table(input int id);
    code[0] = 13'h0403; code[1] = 13'h0402; code[2] = 13'h0603; code[3] = 13'h0602;
    code[4] = 13'h0601; code[5] = 13'h0801; code[6] = 13'h0A01; code[7] = 13'h0C01;
    code[8] = 13'h0E01; code[9] = 13'h0E00;
    if (id == 1) begin
      for (int i = 0; i < 10; i++) code[i] = 13'h0000;
      code[0] = 13'h0201;
    end else if (id == 2) begin
      code[9] = 13'h0000;
    end
  endfunction

  // Scoreboard monitor: every consumed symbol is compared with the queue head.
  always @(negedge Clk_in) begin
    if (!Rst) begin
      if (Err) err_seen++;
      if (Sym_valid && Sym_ready) begin
        if (sb.size() == 0) begin
          chk("sym_unexpected", int'(Sym_out), -1);
        end else begin
          automatic logic [3:0] e = sb.pop_front();
          $display("sym: got %0d expected %0d", Sym_out, e);
          chk("sym_out", int'(Sym_out), int'(e));
        end
      end
    end
  end

  // Starts and ends half a cycle... precisely: starts and ends at posedge+1.
  task automatic load_table();
    Load_table = 1'b1;
    @(negedge Clk_in);
    chk("bit_ready_during_load", int'(Bit_ready), 0);
    @(posedge Clk_in); #1;
    Load_table = 1'b0;
    @(negedge Clk_in);
    chk("tbl_ok_after_load", int'(Tbl_ok), 1);
    @(posedge Clk_in); #1;
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    Bit_in = b;
    Bit_valid = 1'b1;
    @(negedge Clk_in);
    while (!Bit_ready && n < 200) begin
      @(negedge Clk_in);
      n++;
    end
    if (!Bit_ready) chk("bit_accept_timeout", 0, 1);
    @(posedge Clk_in); #1;
    Bit_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rest;

    vecs[0] = '{tab: 0, bits: 32'b11_10_011_0001_0000000, nbits: 18,
                syms: 24'h95210, nsyms: 5, nerr: 0};
    vecs[1] = '{tab: 0, bits: 32'b010_001_00001_000001_0000001, nbits: 24,
                syms: 24'h87643, nsyms: 5, nerr: 0};
    vecs[2] = '{tab: 2, bits: 32'b000000000_11, nbits: 11,
                syms: 24'h00000, nsyms: 1, nerr: 1};
    vecs[3] = '{tab: 1, bits: 32'b000000000_1, nbits: 10,
                syms: 24'h00000, nsyms: 1, nerr: 1};
    set_table(0);

    // Reset state
    repeat (3) @(posedge Clk_in);
    #1 Rst = 1'b0;
    @(negedge Clk_in);
    chk("rst_bit_ready", int'(Bit_ready), 0);
    chk("rst_sym_out", int'(Sym_out), 0);
    chk("rst_sym_valid", int'(Sym_valid), 0);
    chk("rst_err", int'(Err), 0);
    chk("rst_tbl_ok", int'(Tbl_ok), 0);
    @(posedge Clk_in); #1;

    // Table-driven streams
    for (int v = 0; v < 4; v++) begin
      set_table(vecs[v].tab);
      load_table();
      err_seen = 0;
      for (int k = 0; k < vecs[v].nsyms; k++) sb.push_back(vecs[v].syms[4*k +: 4]);
      for (int b = vecs[v].nbits - 1; b >= 0; b--) send_bit(vecs[v].bits[b]);
      repeat (3) @(posedge Clk_in);
      #1;
      $display("vector %0d: %0d symbols outstanding, %0d err pulses", v, sb.size(), err_seen);
      chk("vec_pending_syms", sb.size(), 0);
      chk("vec_err_pulses", err_seen, vecs[v].nerr);
`ifdef HUFF_DEC_ERR_CNT_EN
      chk("vec_err_cnt", int'(Err_cnt), vecs[v].nerr);
`endif
      sb.delete();
    end

    // Back-to-back 1-bit codes: one symbol per cycle, visible the cycle after each bit
    set_table(1);
    load_table();
    repeat (4) sb.push_back(4'd0);
    Bit_in = 1'b1;
    Bit_valid = 1'b1;
    @(negedge Clk_in);
    chk("b2b_valid_before_bits", int'(Sym_valid), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk_in); #1;
      if (k == 3) Bit_valid = 1'b0;
      @(negedge Clk_in);
      chk("b2b_valid", int'(Sym_valid), 1);
    end
    @(negedge Clk_in);
    chk("b2b_valid_after", int'(Sym_valid), 0);
    chk("b2b_pending", sb.size(), 0);
    @(posedge Clk_in); #1;

    // Backpressure: first symbol held, no bits consumed while stalled
    set_table(0);
    load_table();
    sb.push_back(4'd0); sb.push_back(4'd1); sb.push_back(4'd2);
    sb.push_back(4'd5); sb.push_back(4'd9);
    Sym_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    Bit_in = 1'b1;
    Bit_valid = 1'b1;
    repeat (4) begin
      @(negedge Clk_in);
      chk("bp_bit_ready", int'(Bit_ready), 0);
      chk("bp_sym_valid", int'(Sym_valid), 1);
      chk("bp_sym_out", int'(Sym_out), 0);
    end
    @(posedge Clk_in); #1;
    Sym_ready = 1'b1;
    rest = 16'b1_0_011_0001_0000000;
    for (int b = 15; b >= 0; b--) send_bit(rest[b]);
    repeat (3) @(posedge Clk_in);
    #1;
    chk("bp_pending", sb.size(), 0);
    sb.delete();

    // Reload mid-code discards the partial '01'
    err_seen = 0;
    sb.push_back(4'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    load_table();
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (3) @(posedge Clk_in);
    #1;
    chk("reload_pending", sb.size(), 0);
    chk("reload_err", err_seen, 0);
    sb.delete();

    // Reset while a symbol is pending
    Sym_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge Clk_in);
    chk("rst_mid_valid_before", int'(Sym_valid), 1);
    @(posedge Clk_in); #1;
    Rst = 1'b1;
    @(posedge Clk_in); #1;
    Rst = 1'b0;
    @(negedge Clk_in);
    chk("rst_mid_sym_valid", int'(Sym_valid), 0);
    chk("rst_mid_sym_out", int'(Sym_out), 0);
    chk("rst_mid_tbl_ok", int'(Tbl_ok), 0);
    Bit_in = 1'b1;
    Bit_valid = 1'b1;
    repeat (3) begin
      @(negedge Clk_in);
      chk("rst_mid_bit_ready", int'(Bit_ready), 0);
    end
    @(posedge Clk_in); #1;
    Bit_valid = 1'b0;
    Sym_ready = 1'b1;
    load_table();
    chk("rst_mid_bit_ready_loaded", int'(Bit_ready), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
